// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl
// Forwarding and hazard controller sitting just upstream of the EX-stage
// operand muxes. It keeps a small tracker of the destination register held by
// the instructions in EX, MEM and WB. On every ID->EX advance it registers the
// 2-bit mux selects for operands A and B. It also raises a one-cycle ID stall
// when a load in EX feeds the instruction in ID.
//
// Select encoding (matches the mux input order):
//   00 register file, 01 EX/MEM result, 10 MEM/WB result,
//   11 WB-delayed write data (instruction that retired last cycle)

module operand_fwd_ctrl #(
    parameter int REG_BITS = 5,
    parameter int FWD_R0   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                ex_valid,
    output logic                stall_id
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_WBDLY = 2'b11;

    // One tracked producer. The load flag is only consulted while an
    // instruction sits in EX, so it lives beside the EX entry rather than
    // travelling down the pipe with every entry.
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regWrite;
    } producer_t;

    localparam producer_t BUBBLE = '{valid: 1'b0, rd: '0, regWrite: 1'b0};

    producer_t exEntry_q, exEntry_d;
    producer_t memEntry_q, memEntry_d;
    producer_t wbEntry_q, wbEntry_d;
    logic      exMemRead_q, exMemRead_d;
    logic [1:0] fwdA_q, fwdA_d;
    logic [1:0] fwdB_q, fwdB_d;

    logic [1:0] selA;
    logic [1:0] selB;
    logic       loadUseHit;

    // A tracked producer supplies reg r when it is a live register writer of r.
    // Register 0 is hard-wired in the register file, so it is never forwarded
    // unless FWD_R0 explicitly allows it.
    function automatic logic entryMatches(input producer_t e,
                                          input logic [REG_BITS-1:0] r);
        return e.valid && e.regWrite && (e.rd == r) &&
               ((FWD_R0 != 0) || (r != '0));
    endfunction

    // Youngest producer wins: EX is checked before MEM before WB.
    function automatic logic [1:0] selectFor(input logic [REG_BITS-1:0] r,
                                             input producer_t ex,
                                             input producer_t mem,
                                             input producer_t wb);
        if (entryMatches(ex, r)) begin
            return SEL_EXMEM;
        end else if (entryMatches(mem, r)) begin
            return SEL_MEMWB;
        end else if (entryMatches(wb, r)) begin
            return SEL_WBDLY;
        end
        return SEL_RF;
    endfunction

    // Operand selects for the instruction currently in ID, against the
    // tracker contents before this edge's shift.
    always_comb begin
        selA = selectFor(id_rs, exEntry_q, memEntry_q, wbEntry_q);
        selB = id_use_rt ? selectFor(id_rt, exEntry_q, memEntry_q, wbEntry_q)
                         : SEL_RF;
    end

    // Load-use detection: a load in EX cannot forward in time for the
    // instruction in ID, which must wait one cycle. A freeze or a flush
    // already takes care of ID, and reset discards everything.
    always_comb begin
        loadUseHit = exMemRead_q &&
                     (entryMatches(exEntry_q, id_rs) ||
                      (id_use_rt && entryMatches(exEntry_q, id_rt)));
        stall_id   = !rst && !hold && !flush && id_valid && loadUseHit;
    end

    // Tracker shift and select update, in priority hold > flush > stall > advance.
    always_comb begin
        exEntry_d   = exEntry_q;
        memEntry_d  = memEntry_q;
        wbEntry_d   = wbEntry_q;
        exMemRead_d = exMemRead_q;
        fwdA_d      = fwdA_q;
        fwdB_d      = fwdB_q;

        if (hold) begin
            exEntry_d = exEntry_q;
        end else if (flush) begin
            wbEntry_d   = memEntry_q;
            memEntry_d  = BUBBLE;
            exEntry_d   = BUBBLE;
            exMemRead_d = 1'b0;
            fwdA_d      = SEL_RF;
            fwdB_d      = SEL_RF;
        end else if (stall_id) begin
            wbEntry_d   = memEntry_q;
            memEntry_d  = exEntry_q;
            exEntry_d   = BUBBLE;
            exMemRead_d = 1'b0;
            fwdA_d      = SEL_RF;
            fwdB_d      = SEL_RF;
        end else begin
            wbEntry_d   = memEntry_q;
            memEntry_d  = exEntry_q;
            exEntry_d   = '{valid: id_valid, rd: id_rd, regWrite: id_reg_write};
            exMemRead_d = id_valid && id_mem_read;
            fwdA_d      = id_valid ? selA : SEL_RF;
            fwdB_d      = id_valid ? selB : SEL_RF;
        end
    end

    // State register; reset drops all in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            exEntry_q   <= BUBBLE;
            memEntry_q  <= BUBBLE;
            wbEntry_q   <= BUBBLE;
            exMemRead_q <= 1'b0;
            fwdA_q      <= SEL_RF;
            fwdB_q      <= SEL_RF;
        end else begin
            exEntry_q   <= exEntry_d;
            memEntry_q  <= memEntry_d;
            wbEntry_q   <= wbEntry_d;
            exMemRead_q <= exMemRead_d;
            fwdA_q      <= fwdA_d;
            fwdB_q      <= fwdB_d;
        end
    end

    assign fwd_a    = fwdA_q;
    assign fwd_b    = fwdB_q;
    assign ex_valid = exEntry_q.valid;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Testbench for operand_fwd_ctrl.
// Stimulus drives one ID instruction per cycle and pushes the outputs
// expected during that cycle. Those are the combinational stall plus the
// registered selects left by the previous edge. A separate monitor pops each
// expectation mid-cycle and compares.

module tb_operand_fwd_ctrl;

    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          flush;
    logic          id_valid;
    logic [RB-1:0] id_rs;
    logic [RB-1:0] id_rt;
    logic          id_use_rt;
    logic [RB-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          ex_valid;
    logic          stall_id;

    typedef struct packed {
        logic       stall;
        logic       exValid;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
    } expect_t;

    expect_t expQ[$];
    string   tagQ[$];
    int      compared   = 0;
    int      mismatched = 0;

    always #5 clk = ~clk;

    operand_fwd_ctrl #(.REG_BITS(RB), .FWD_R0(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .ex_valid     (ex_valid),
        .stall_id     (stall_id)
    );

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected while these inputs are applied.
    task automatic applyStimulus(input string tag, input bit push,
                                 input logic r, input logic h, input logic f,
                                 input logic v, input logic [RB-1:0] rs,
                                 input logic [RB-1:0] rt, input logic useRt,
                                 input logic [RB-1:0] rd, input logic rw,
                                 input logic mr, input logic eStall,
                                 input logic eEx, input logic [1:0] eA,
                                 input logic [1:0] eB);
        @(posedge clk);
        #1;
        rst          = r;
        hold         = h;
        flush        = f;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rt    = useRt;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        if (push) begin
            expQ.push_back('{stall: eStall, exValid: eEx, fwdA: eA, fwdB: eB});
            tagQ.push_back(tag);
        end
    endtask

    // Ordinary instruction with no control inputs active.
    task automatic instr(input string tag, input logic [RB-1:0] rs,
                         input logic [RB-1:0] rt, input logic useRt,
                         input logic [RB-1:0] rd, input logic rw, input logic mr,
                         input logic eStall, input logic eEx,
                         input logic [1:0] eA, input logic [1:0] eB);
        applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rs, rt, useRt, rd,
                      rw, mr, eStall, eEx, eA, eB);
    endtask

    // Empty ID slot.
    task automatic nop(input string tag, input logic eStall, input logic eEx,
                       input logic [1:0] eA, input logic [1:0] eB);
        applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0,
                      1'b0, 1'b0, eStall, eEx, eA, eB);
    endtask

    task automatic checkOutput(input string tag, input string field,
                               input logic [1:0] act, input logic [1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    // Monitor: mid-cycle, pop the pending expectation and compare.
    initial begin
        expect_t e;
        string   t;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                checkOutput(t, "stall_id", {1'b0, stall_id}, {1'b0, e.stall});
                checkOutput(t, "ex_valid", {1'b0, ex_valid}, {1'b0, e.exValid});
                checkOutput(t, "fwd_a", fwd_a, e.fwdA);
                checkOutput(t, "fwd_b", fwd_b, e.fwdB);
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_use_rt = 1'b0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;

        // Reset
        applyStimulus("rst0", 1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("rst1", 1'b1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back dependency on r3
        instr("b2b_i1",   1,  2, 1,  3, 1, 0,  0, 0, 2'd0, 2'd0);
        instr("b2b_i2",   3,  0, 0,  6, 1, 0,  0, 1, 2'd0, 2'd0);
        nop  ("b2b_chk",                       0, 1, 2'd1, 2'd0);

        // Distances 2, 3 and 4 from the r5 producer
        instr("d2_prod",  1,  2, 1,  5, 1, 0,  0, 0, 2'd0, 2'd0);
        instr("d2_ind",   1,  2, 1, 10, 1, 0,  0, 1, 2'd0, 2'd0);
        instr("d2_cons",  1,  5, 1, 11, 1, 0,  0, 1, 2'd0, 2'd0);
        instr("d3_cons",  1,  5, 1, 12, 1, 0,  0, 1, 2'd0, 2'd2);
        instr("d4_cons",  1,  5, 1, 13, 1, 0,  0, 1, 2'd0, 2'd3);

        // Youngest producer wins
        instr("yw_i1",    1,  2, 1,  7, 1, 0,  0, 1, 2'd0, 2'd0);
        instr("yw_i2",    1,  2, 1,  7, 1, 0,  0, 1, 2'd0, 2'd0);
        instr("yw_i3",    7,  7, 1, 14, 1, 0,  0, 1, 2'd0, 2'd0);

        // Load-use: one stall cycle, then forward from MEM/WB
        instr("lu_load",  1,  0, 0,  4, 1, 1,  0, 1, 2'd1, 2'd1);
        instr("lu_stall", 4,  2, 1, 15, 1, 0,  1, 1, 2'd0, 2'd0);
        instr("lu_retry", 4,  2, 1, 15, 1, 0,  0, 0, 2'd0, 2'd0);

        // r0 never forwarded; rt ignored when not used; WB-delayed path on rs
        instr("r0_wr",    1,  2, 1,  0, 1, 0,  0, 1, 2'd2, 2'd0);
        instr("r0_rd",    0,  0, 1,  9, 1, 0,  0, 1, 2'd0, 2'd0);
        instr("rt_mask", 15,  9, 0, 16, 1, 0,  0, 1, 2'd0, 2'd0);

        // Flush beats load-use and discards the load in EX
        instr("fl_load",  1,  2, 0,  8, 1, 1,  0, 1, 2'd3, 2'd0);
        applyStimulus("fl_flush", 1'b1, 0, 0, 1, 1, 8, 2, 0, 19, 1, 0, 0, 1, 2'd0, 2'd0);
        instr("fl_after", 8, 16, 1, 17, 1, 0,  0, 0, 2'd0, 2'd0);

        // Hold for three cycles: outputs and tracker frozen
        for (int k = 0; k < 3; k++) begin
            applyStimulus("hold_k", 1'b1, 0, 1, 0, 1, 17, 2, 1, 18, 1, 0, 0, 1, 2'd0, 2'd3);
        end
        instr("hold_rel",17,  2, 1, 18, 1, 0,  0, 1, 2'd0, 2'd3);

        // Hold and reset both suppress the stall; reset clears tracking
        instr("rs_load",  1,  2, 0, 20, 1, 1,  0, 1, 2'd1, 2'd0);
        applyStimulus("rs_hold",  1'b1, 0, 1, 0, 1, 20, 2, 0, 21, 1, 0, 0, 1, 2'd0, 2'd0);
        applyStimulus("rs_reset", 1'b1, 1, 0, 0, 1, 20, 2, 0, 21, 1, 0, 0, 1, 2'd0, 2'd0);
        instr("rs_dep",  20, 17, 1, 21, 1, 0,  0, 0, 2'd0, 2'd0);
        nop  ("rs_chk",                        0, 1, 2'd0, 2'd0);
        nop  ("tail",                          0, 0, 2'd0, 2'd0);

        // Let the monitor drain, bounded
        for (int k = 0; k < 10; k++) begin
            if (expQ.size() != 0) @(negedge clk);
        end
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_fwd_ctrl.md
Name: operand_fwd_ctrl

Overview:
Forwarding and hazard controller directly upstream of the EX-stage operand 4-to-1 multiplexers. It tracks the destination register of every in-flight instruction in EX, MEM and WB. On each ID->EX advance it registers the 2-bit select codes that drive the A and B operand muxes. It also detects load-use hazards and requests a one-cycle ID stall with bubble insertion.

Parameters:
REG_BITS, 5, width of register specifiers
FWD_R0, 0, 1 = allow forwarding of register 0; 0 = register 0 never forwarded

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
hold  input  1  global pipeline freeze; all internal state retained
flush  input  1  kill the instruction in ID and the instruction in EX (branch taken in EX)
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_BITS  source A specifier in ID
id_rt  input  REG_BITS  source B specifier in ID
id_use_rt  input  1  ID instruction reads rt as an operand
id_rd  input  REG_BITS  destination specifier in ID
id_reg_write  input  1  ID instruction writes the register file
id_mem_read  input  1  ID instruction is a load
fwd_a  output  2  registered select for the operand-A mux in EX
fwd_b  output  2  registered select for the operand-B mux in EX
ex_valid  output  1  EX stage holds a real (non-bubble) instruction
stall_id  output  1  combinational; PC and IF/ID must hold this cycle

Behaviour:
- Select encoding, matching the mux inputs:
  - 00 = register-file value
  - 01 = EX/MEM result
  - 10 = MEM/WB result
  - 11 = WB-delayed write data (instruction retired last cycle)
- Internal tracker: three entries, EX, MEM and WB. Each entry holds {valid, rd, reg_write, mem_read}.
- Reset (rst=1 at the edge): all tracker entries invalid; fwd_a=fwd_b=00; ex_valid=0. stall_id is 0 while rst=1.
- An entry "matches" reg r when all of the following hold:
  - valid=1
  - reg_write=1
  - rd==r
  - r!=0, unless FWD_R0=1
- Select computation at advance, evaluated against the current tracker before the shift:
  - If the EX entry matches: 01.
  - Else if the MEM entry matches: 10.
  - Else if the WB entry matches: 11.
  - Else: 00.
  - Youngest producer always wins.
  - fwd_b is forced to 00 when id_use_rt=0.
- Load-use: stall_id=1 when all of the following hold:
  - id_valid=1
  - EX entry matches id_rs, or EX entry matches id_rt with id_use_rt=1
  - EX entry has mem_read=1
  - hold=0 and flush=0
- Stall timing:
  - A stall lasts exactly one cycle. After the shift, the load sits in MEM and forwarding selects 10.
- Per-edge update, priority rst > hold > flush > stall > normal:
  - hold: no state change. stall_id=0 (the freeze already holds ID).
  - flush: the EX entry is discarded. WB<-MEM, MEM<-bubble, EX<-bubble, ex_valid=0, fwd_a=fwd_b=00.
  - stall: WB<-MEM, MEM<-EX, EX<-bubble, ex_valid=0, fwd_a=fwd_b=00.
  - normal: WB<-MEM, MEM<-EX, EX<-ID fields, with valid=id_valid. ex_valid=id_valid. fwd_a/fwd_b take the computed selects, or 00 if id_valid=0.
- Bubble entries never match.
- Latency: selects are visible on fwd_a/fwd_b one cycle after the instruction is presented in ID. This is the same cycle the instruction is in EX.
- Reset mid-stall or mid-flush: reset wins; all in-flight tracking is lost.

Test Plan:
- Back-to-back dependency: I1 writes r3, then I2 reads rs=r3 on the next cycle -> in I2's EX cycle fwd_a=01, ex_valid=1, stall_id never asserted.
- Distance 2 and 3:
  - I1 writes r5, one independent instruction, then I3 reads rt=r5 with id_use_rt=1 -> fwd_b=10.
  - With two independent instructions in between -> fwd_b=11.
  - With three in between -> fwd_b=00.
- Youngest wins: I1 and I2 both write r7, I3 reads rs=r7 -> fwd_a=01, not 10.
- Load-use: load r4 followed by an add reading rs=r4:
  - stall_id=1 for exactly one cycle.
  - In that EX cycle, ex_valid=0 and fwd=00.
  - Next cycle the add is in EX with fwd_a=10.
- r0 and rt masking:
  - I1 writes r0, I2 reads r0 -> fwd_a=00 with FWD_R0=0.
  - I2 reads rt=r9 with id_use_rt=0 while r9 is in flight -> fwd_b=00.
- Control priority:
  - flush during a load-use condition -> stall_id=0, EX bubble, ex_valid=0.
  - hold=1 for 3 cycles -> fwd and ex_valid unchanged.
  - rst=1 asserted mid-stream -> next cycle fwd_a=fwd_b=00, ex_valid=0, and a following dependent instruction gets 00.
